// File: rtl/sharp_lcd_pkg.sv
// rtl/sharp_lcd_pkg.sv - shared state encoding and field widths for the LS013B7DH01 link
package sharp_lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MODE,
    ADDR,
    DATA,
    DUMMY,
    TRAIL,
    TRAIL_END,
    ERR
  } state_t;

  localparam int MODE_BITS  = 8;
  localparam int ADDR_BITS  = 8;
  localparam int DUMMY_BITS = 8;

endpackage

// File: rtl/sharp_lcd_rx_sync.sv
// rtl/sharp_lcd_rx_sync.sv - pin synchroniser with registered scs edges and gated sclk rise
module sharp_lcd_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_scs,
  input  logic i_sclk,
  input  logic i_si,
  output logic o_scs,
  output logic o_scs_rise,
  output logic o_scs_fall,
  output logic o_sclk_rise,
  output logic o_si
);

  logic [SYNC_STAGES-1:0] r_scs_q;
  logic [SYNC_STAGES-1:0] r_sclk_q;
  logic [SYNC_STAGES-1:0] r_si_q;
  logic r_scs_d;
  logic r_sclk_d;
  logic r_scs;
  logic r_scs_rise;
  logic r_scs_fall;
  logic r_sclk_rise;
  logic r_si;
  logic w_scs;
  logic w_sclk;
  logic w_si;

  assign w_scs  = r_scs_q[SYNC_STAGES-1];
  assign w_sclk = r_sclk_q[SYNC_STAGES-1];
  assign w_si   = r_si_q[SYNC_STAGES-1];

  // Edge pulses are registered so SI, SCS and the edges all leave on the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scs_q     <= '0;
      r_sclk_q    <= '0;
      r_si_q      <= '0;
      r_scs_d     <= 1'b0;
      r_sclk_d    <= 1'b0;
      r_scs       <= 1'b0;
      r_scs_rise  <= 1'b0;
      r_scs_fall  <= 1'b0;
      r_sclk_rise <= 1'b0;
      r_si        <= 1'b0;
    end else begin
      r_scs_q     <= {r_scs_q[SYNC_STAGES-2:0], i_scs};
      r_sclk_q    <= {r_sclk_q[SYNC_STAGES-2:0], i_sclk};
      r_si_q      <= {r_si_q[SYNC_STAGES-2:0], i_si};
      r_scs_d     <= w_scs;
      r_sclk_d    <= w_sclk;
      r_scs       <= w_scs;
      r_scs_rise  <= w_scs & ~r_scs_d;
      r_scs_fall  <= ~w_scs & r_scs_d;
      r_sclk_rise <= w_sclk & ~r_sclk_d & w_scs;
      r_si        <= w_si;
    end
  end

  assign o_scs       = r_scs;
  assign o_scs_rise  = r_scs_rise;
  assign o_scs_fall  = r_scs_fall;
  assign o_sclk_rise = r_sclk_rise;
  assign o_si        = r_si;

endmodule

// File: rtl/sharp_lcd_rx.sv
// rtl/sharp_lcd_rx.sv - LS013B7DH01 serial receiver: mode, line address/pixels and trailer decode
module sharp_lcd_rx
  import sharp_lcd_pkg::*;
#(
  parameter int LINE_PIXELS = 144,
  parameter int MAX_LINE    = 168,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   Clk_12MHz,
  input  logic                   Rst_n,
  input  logic                   lcd_scs,
  input  logic                   lcd_sclk,
  input  logic                   lcd_si,
  output logic                   mode_valid,
  output logic                   mode_write,
  output logic                   mode_vcom,
  output logic                   mode_clear,
  output logic                   line_valid,
  output logic [7:0]             line_addr,
  output logic [LINE_PIXELS-1:0] line_data,
  output logic                   frame_done,
  output logic                   proto_err
);

  localparam logic [7:0] CNT_MAX    = 8'(LINE_PIXELS);
  localparam logic [7:0] LAST_PIX   = 8'(LINE_PIXELS - 1);
  localparam logic [7:0] LAST_MODE  = 8'(MODE_BITS - 1);
  localparam logic [7:0] LAST_ADDR  = 8'(ADDR_BITS - 1);
  localparam logic [7:0] LAST_DUMMY = 8'(DUMMY_BITS - 1);
  localparam logic [7:0] ADDR_MAX   = 8'(MAX_LINE);

  logic w_scs;
  logic w_scs_rise;
  logic w_scs_fall;
  logic w_sclk_rise;
  logic w_si;
  logic [7:0] w_byte;
  logic [7:0] w_cnt_inc;
  logic [LINE_PIXELS-1:0] w_data_next;

  state_t r_state;
  logic [7:0] r_cnt;
  logic [7:0] r_sh;
  logic [LINE_PIXELS-1:0] r_data;
  logic r_mode_valid;
  logic r_mode_write;
  logic r_mode_vcom;
  logic r_mode_clear;
  logic r_line_valid;
  logic [7:0] r_line_addr;
  logic [LINE_PIXELS-1:0] r_line_data;
  logic r_frame_done;
  logic r_proto_err;

  sharp_lcd_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk       (Clk_12MHz),
    .i_rst_n     (Rst_n),
    .i_scs       (lcd_scs),
    .i_sclk      (lcd_sclk),
    .i_si        (lcd_si),
    .o_scs       (w_scs),
    .o_scs_rise  (w_scs_rise),
    .o_scs_fall  (w_scs_fall),
    .o_sclk_rise (w_sclk_rise),
    .o_si        (w_si)
  );

  // First bit on the wire ends up in bit 0 of both shifters.
  assign w_byte      = {w_si, r_sh[7:1]};
  assign w_data_next = {w_si, r_data[LINE_PIXELS-1:1]};
  assign w_cnt_inc   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 8'd1;

  always_ff @(posedge Clk_12MHz or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_sh         <= '0;
      r_data       <= '0;
      r_mode_valid <= 1'b0;
      r_mode_write <= 1'b0;
      r_mode_vcom  <= 1'b0;
      r_mode_clear <= 1'b0;
      r_line_valid <= 1'b0;
      r_line_addr  <= '0;
      r_line_data  <= '0;
      r_frame_done <= 1'b0;
      r_proto_err  <= 1'b0;
    end else begin
      r_mode_valid <= 1'b0;
      r_line_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_proto_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_scs_rise) begin
            r_state <= MODE;
            r_cnt   <= '0;
          end
        end
        MODE, ADDR, DATA, DUMMY, TRAIL: begin
          // SCS fall outranks a coincident SCLK rise; that bit is dropped.
          if (w_scs_fall) begin
            r_proto_err <= 1'b1;
            r_state     <= IDLE;
            r_cnt       <= '0;
          end else if (w_sclk_rise) begin
            r_cnt <= w_cnt_inc;
            // r_sh keeps the line address through DATA.
            if (r_state != DATA) r_sh <= w_byte;
            case (r_state)
              MODE: begin
                if (r_cnt == LAST_MODE) begin
                  r_mode_write <= w_byte[0];
                  r_mode_vcom  <= w_byte[1];
                  r_mode_clear <= w_byte[2];
                  r_mode_valid <= 1'b1;
                  r_cnt        <= '0;
                  r_state      <= w_byte[2] ? TRAIL : ADDR;
                end
              end
              ADDR: begin
                if (r_cnt == LAST_ADDR) begin
                  r_cnt <= '0;
                  if (w_byte == 8'd0) begin
                    r_state <= TRAIL_END;
                  end else if (w_byte > ADDR_MAX) begin
                    r_proto_err <= 1'b1;
                    r_state     <= ERR;
                  end else begin
                    r_state <= DATA;
                  end
                end
              end
              DATA: begin
                r_data <= w_data_next;
                if (r_cnt == LAST_PIX) begin
                  r_line_addr  <= r_sh;
                  r_line_data  <= w_data_next;
                  r_line_valid <= 1'b1;
                  r_cnt        <= '0;
                  r_state      <= DUMMY;
                end
              end
              DUMMY: begin
                if (r_cnt == LAST_DUMMY) begin
                  r_cnt   <= '0;
                  r_state <= ADDR;
                end
              end
              TRAIL: begin
                if (r_cnt == LAST_DUMMY) begin
                  r_cnt   <= '0;
                  r_state <= TRAIL_END;
                end
              end
              default: ;
            endcase
          end
        end
        TRAIL_END: begin
          if (w_scs_fall) begin
            r_frame_done <= 1'b1;
            r_state      <= IDLE;
          end else if (w_sclk_rise) begin
            r_proto_err <= 1'b1;
            r_state     <= ERR;
          end
        end
        ERR: begin
          if (!w_scs) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mode_valid = r_mode_valid;
  assign mode_write = r_mode_write;
  assign mode_vcom  = r_mode_vcom;
  assign mode_clear = r_mode_clear;
  assign line_valid = r_line_valid;
  assign line_addr  = r_line_addr;
  assign line_data  = r_line_data;
  assign frame_done = r_frame_done;
  assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_sharp_lcd_rx.sv
// tb/tb_sharp_lcd_rx.sv - scoreboard bench for the LS013B7DH01 serial receiver
`timescale 1ns/1ps
module tb_sharp_lcd_rx;

  localparam int LP  = 144;
  localparam int ML  = 168;
  localparam int SS  = 2;
  localparam int LAT = SS + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scs = 1'b0;
  logic sclk = 1'b0;
  logic si = 1'b0;
  logic mode_valid, mode_write, mode_vcom, mode_clear;
  logic line_valid, frame_done, proto_err;
  logic [7:0] line_addr;
  logic [LP-1:0] line_data;

  typedef struct packed { logic w; logic v; logic c; } mode_t;
  typedef struct packed { logic [7:0] a; logic [LP-1:0] d; } line_t;

  mode_t mode_q[$];
  line_t line_q[$];
  int n_chk = 0;
  int n_pass = 0;
  int fd_cnt = 0;
  int pe_cnt = 0;
  int cyc = 0;
  int last_rise_cyc = 0;
  int line_rise_cyc = 0;
  int lv_cyc = 0;
  int scs_fall_cyc = 0;
  int fd_cyc = 0;
  int half = 6;
  int jit = 0;
  logic [7:0] exp_addr = 8'd0;
  logic [LP-1:0] exp_data = '0;

  always #42 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sharp_lcd_rx #(.LINE_PIXELS(LP), .MAX_LINE(ML), .SYNC_STAGES(SS)) dut (
    .Clk_12MHz (clk),
    .Rst_n     (rst_n),
    .lcd_scs   (scs),
    .lcd_sclk  (sclk),
    .lcd_si    (si),
    .mode_valid(mode_valid),
    .mode_write(mode_write),
    .mode_vcom (mode_vcom),
    .mode_clear(mode_clear),
    .line_valid(line_valid),
    .line_addr (line_addr),
    .line_data (line_data),
    .frame_done(frame_done),
    .proto_err (proto_err)
  );

  always @(negedge clk) begin : mon
    mode_t m;
    line_t l;
    if (rst_n) begin
      if (mode_valid && line_valid) begin
        n_chk++;
        $display("FAIL pulse_overlap mode_valid=1 line_valid=1 at cycle %0d, required never together", cyc);
      end
      if (mode_valid) begin
        n_chk++;
        if (mode_q.size() == 0) begin
          $display("FAIL mode_unexpected mode_valid at cycle %0d, required none", cyc);
        end else begin
          m = mode_q.pop_front();
          if ({mode_write, mode_vcom, mode_clear} !== {m.w, m.v, m.c})
            $display("FAIL mode_bits got wvc=%b%b%b required %b%b%b", mode_write, mode_vcom, mode_clear, m.w, m.v, m.c);
          else
            n_pass++;
        end
      end
      if (line_valid) begin
        n_chk++;
        lv_cyc = cyc;
        if (line_q.size() == 0) begin
          $display("FAIL line_unexpected line_valid addr=%0d at cycle %0d, required none", line_addr, cyc);
        end else begin
          l = line_q.pop_front();
          if (line_addr !== l.a || line_data !== l.d)
            $display("FAIL line_content got addr=%0d data=%h required addr=%0d data=%h", line_addr, line_data, l.a, l.d);
          else
            n_pass++;
        end
      end
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
      if (proto_err) pe_cnt++;
    end
  end

  initial begin
    #6000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hp();
    int h;
    h = half + int'($urandom_range(0, 2 * jit)) - jit;
    wait_cyc(h);
  endtask

  task automatic send_bit(input logic b);
    si = b;
    hp();
    sclk = 1'b1;
    last_rise_cyc = cyc;
    hp();
    sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic scs_up();
    scs = 1'b1;
    wait_cyc(half);
  endtask

  task automatic scs_down();
    scs = 1'b0;
    scs_fall_cyc = cyc;
    wait_cyc(12);
  endtask

  task automatic send_mode(input logic [7:0] b);
    mode_t m;
    m.w = b[0];
    m.v = b[1];
    m.c = b[2];
    mode_q.push_back(m);
    send_byte(b);
  endtask

  task automatic send_line(input logic [7:0] a, input logic [LP-1:0] d);
    line_t l;
    l.a = a;
    l.d = d;
    line_q.push_back(l);
    send_byte(a);
    for (int i = 0; i < LP; i++) send_bit(d[i]);
    line_rise_cyc = last_rise_cyc;
    send_byte(8'h00);
    exp_addr = a;
    exp_data = d;
  endtask

  function automatic logic [LP-1:0] rand_line();
    logic [LP-1:0] d;
    for (int i = 0; i < LP; i++) d[i] = 1'($urandom_range(0, 1));
    return d;
  endfunction

  task automatic test_reset();
    wait_cyc(5);
    n_chk++;
    if ({mode_valid, mode_write, mode_vcom, mode_clear, line_valid, line_addr, line_data, frame_done, proto_err} !== '0)
      $display("FAIL reset_outputs got nonzero outputs, required all 0");
    else
      n_pass++;
    rst_n = 1'b1;
    wait_cyc(5);
  endtask

  task automatic test_single_line(input string tag);
    int fd0, pe0;
    logic [LP-1:0] d;
    fd0 = fd_cnt;
    pe0 = pe_cnt;
    d = {18{8'hAA}};
    scs_up();
    send_mode(8'h01);
    send_line(8'd1, d);
    send_byte(8'h00);
    scs_down();
    n_chk++;
    if (fd_cnt - fd0 != 1) $display("FAIL %s frame_done_count got %0d required 1", tag, fd_cnt - fd0);
    else n_pass++;
    n_chk++;
    if (pe_cnt - pe0 != 0) $display("FAIL %s proto_err_count got %0d required 0", tag, pe_cnt - pe0);
    else n_pass++;
    n_chk++;
    if (mode_q.size() != 0 || line_q.size() != 0)
      $display("FAIL %s scoreboard_left got mode=%0d line=%0d required 0/0", tag, mode_q.size(), line_q.size());
    else n_pass++;
    n_chk++;
    if (mode_write !== 1'b1 || line_addr !== 8'd1 || line_data !== d)
      $display("FAIL %s held_outputs got write=%b addr=%0d required write=1 addr=1", tag, mode_write, line_addr);
    else n_pass++;
    n_chk++;
    if (lv_cyc - line_rise_cyc != LAT)
      $display("FAIL %s line_latency got %0d required %0d", tag, lv_cyc - line_rise_cyc, LAT);
    else n_pass++;
    n_chk++;
    if (fd_cyc - scs_fall_cyc != LAT)
      $display("FAIL %s frame_latency got %0d required %0d", tag, fd_cyc - scs_fall_cyc, LAT);
    else n_pass++;
  endtask

  task automatic test_multi_line();
    int fd0, pe0;
    fd0 = fd_cnt;
    pe0 = pe_cnt;
    scs_up();
    send_mode(8'h03);
    send_line(8'd5, rand_line());
    send_line(8'd6, rand_line());
    send_line(8'd168, rand_line());
    send_byte(8'h00);
    scs_down();
    n_chk++;
    if (fd_cnt - fd0 != 1 || pe_cnt - pe0 != 0)
      $display("FAIL multi_counts got fd=%0d pe=%0d required fd=1 pe=0", fd_cnt - fd0, pe_cnt - pe0);
    else n_pass++;
    n_chk++;
    if (line_q.size() != 0) $display("FAIL multi_lines_left got %0d required 0", line_q.size());
    else n_pass++;
  endtask

  task automatic test_clear();
    int fd0, pe0;
    fd0 = fd_cnt;
    pe0 = pe_cnt;
    scs_up();
    send_mode(8'h04);
    send_byte(8'h00);
    scs_down();
    n_chk++;
    if (fd_cnt - fd0 != 1 || pe_cnt - pe0 != 0)
      $display("FAIL clear_counts got fd=%0d pe=%0d required fd=1 pe=0", fd_cnt - fd0, pe_cnt - pe0);
    else n_pass++;
    n_chk++;
    if (mode_clear !== 1'b1 || mode_write !== 1'b0 || line_addr !== exp_addr)
      $display("FAIL clear_held got clear=%b write=%b addr=%0d required 1 0 %0d", mode_clear, mode_write, line_addr, exp_addr);
    else n_pass++;
  endtask

  task automatic test_partial_line();
    int fd0, pe0;
    fd0 = fd_cnt;
    pe0 = pe_cnt;
    scs_up();
    send_mode(8'h01);
    send_byte(8'd10);
    for (int i = 0; i < 70; i++) send_bit(1'($urandom_range(0, 1)));
    scs_down();
    n_chk++;
    if (pe_cnt - pe0 != 1 || fd_cnt - fd0 != 0)
      $display("FAIL partial_counts got pe=%0d fd=%0d required pe=1 fd=0", pe_cnt - pe0, fd_cnt - fd0);
    else n_pass++;
    n_chk++;
    if (line_addr !== exp_addr || line_data !== exp_data)
      $display("FAIL partial_held got addr=%0d required %0d", line_addr, exp_addr);
    else n_pass++;
    fd0 = fd_cnt;
    pe0 = pe_cnt;
    scs_up();
    send_mode(8'h01);
    send_line(8'd10, rand_line());
    send_byte(8'h00);
    scs_down();
    n_chk++;
    if (fd_cnt - fd0 != 1 || pe_cnt - pe0 != 0 || line_addr !== 8'd10)
      $display("FAIL partial_recover got fd=%0d pe=%0d addr=%0d required 1 0 10", fd_cnt - fd0, pe_cnt - pe0, line_addr);
    else n_pass++;
  endtask

  task automatic test_bad_addr();
    int fd0, pe0;
    fd0 = fd_cnt;
    pe0 = pe_cnt;
    scs_up();
    send_mode(8'h01);
    send_byte(8'd169);
    send_byte(8'h55);
    scs_down();
    n_chk++;
    if (pe_cnt - pe0 != 1 || fd_cnt - fd0 != 0)
      $display("FAIL addr169 got pe=%0d fd=%0d required pe=1 fd=0", pe_cnt - pe0, fd_cnt - fd0);
    else n_pass++;
    fd0 = fd_cnt;
    pe0 = pe_cnt;
    scs_up();
    send_mode(8'h01);
    send_byte(8'd0);
    send_byte(8'hFF);
    scs_down();
    n_chk++;
    if (pe_cnt - pe0 != 1 || fd_cnt - fd0 != 0)
      $display("FAIL trailer_extra got pe=%0d fd=%0d required pe=1 fd=0", pe_cnt - pe0, fd_cnt - fd0);
    else n_pass++;
    fd0 = fd_cnt;
    pe0 = pe_cnt;
    scs_up();
    send_mode(8'h01);
    send_line(8'd2, rand_line());
    send_byte(8'h00);
    scs_down();
    n_chk++;
    if (fd_cnt - fd0 != 1 || pe_cnt - pe0 != 0 || line_addr !== 8'd2)
      $display("FAIL bad_addr_recover got fd=%0d pe=%0d addr=%0d required 1 0 2", fd_cnt - fd0, pe_cnt - pe0, line_addr);
    else n_pass++;
  endtask

  task automatic test_reset_mid_data();
    int fd0, pe0;
    scs_up();
    send_mode(8'h01);
    send_byte(8'd20);
    for (int i = 0; i < 50; i++) send_bit(1'($urandom_range(0, 1)));
    rst_n = 1'b0;
    scs = 1'b0;
    sclk = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++;
      if ({mode_valid, mode_write, mode_vcom, mode_clear, line_valid, line_addr, line_data, frame_done, proto_err} !== '0)
        $display("FAIL reset_mid_data cycle %0d got nonzero outputs, required all 0", i);
      else n_pass++;
    end
    rst_n = 1'b1;
    wait_cyc(6);
    fd0 = fd_cnt;
    pe0 = pe_cnt;
    scs_up();
    send_mode(8'h01);
    send_line(8'd33, rand_line());
    send_byte(8'h00);
    scs_down();
    n_chk++;
    if (fd_cnt - fd0 != 1 || pe_cnt - pe0 != 0 || line_q.size() != 0)
      $display("FAIL reset_recover got fd=%0d pe=%0d lines_left=%0d required 1 0 0", fd_cnt - fd0, pe_cnt - pe0, line_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_line("single_1mhz");
    test_multi_line();
    test_clear();
    test_partial_line();
    test_bad_addr();
    test_reset_mid_data();
    half = 6;
    jit = 2;
    test_single_line("single_1mhz_jitter");
    half = 15;
    jit = 4;
    test_single_line("single_400khz_jitter");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
